// File: rtl/pipe_pkg.sv
// Shared types for pipeline stage registers: stage state encoding, occupancy
// width, per-stage payload structs and a state-to-occupancy helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int OCC_W = 2;

  // MEM/WB payload, passed packed as in_data of the MEM/WB stage register.
  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd_addr;
    logic [2:0]  funct3;
    logic        mem_read;
    logic [31:0] csr_data;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] pc;
  } mem_wb_payload_t;

  // Number of valid entries held in a given state.
  function automatic logic [OCC_W-1:0] state_occupancy(pipe_state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle of a pipeline stage register: upstream valid/ready/data,
// downstream valid/ready/data, stall/kill controls and occupancy.
// master = the surrounding pipeline, slave = the stage register itself.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;
  logic                       hold;
  logic                       flush;
  logic [pipe_pkg::OCC_W-1:0] occupancy;

  modport master (
    output in_valid, in_data, out_ready, hold, flush,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready, hold, flush,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/pipe_slot_reg.sv
// One payload slot of a stage register: loads only when enabled, resets
// asynchronously to RESET_VAL.
module pipe_slot_reg #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Payload changes only on an explicit load, never on its own.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) q <= RESET_VAL;
    else if (load) q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, hold (stall) and
// flush (bubble insertion).
// Optional feature macro PIPE_SKID_BUF_EN: when defined the stage has a second
// (skid) entry and a registered in_ready; when undefined it is a single entry
// whose in_ready follows out_ready combinationally.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              resetn,
  pipe_stage_reg_if.slave   bus
);

  pipe_state_e       state, state_n;
  logic              main_valid;
  logic              in_fire;
  logic              out_fire;
  logic              load_main;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q;

  assign main_valid    = (state != ST_EMPTY);
  assign bus.out_valid = main_valid & ~bus.hold;
  assign in_fire       = bus.in_valid & bus.in_ready & ~bus.hold & ~bus.flush;
  assign out_fire      = bus.out_valid & bus.out_ready;
  assign bus.out_data  = main_q;
  assign bus.occupancy = state_occupancy(state);

`ifdef PIPE_SKID_BUF_EN
  logic              load_skid;
  logic              main_from_skid;
  logic              in_ready_q;
  logic [DATA_W-1:0] skid_q;

  // in_ready is a flop so upstream never sees a path from out_ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) in_ready_q <= 1'b0;
    else in_ready_q <= (state_n != ST_FULL);
  end

  assign bus.in_ready = in_ready_q & ~bus.hold;
  assign main_d       = main_from_skid ? skid_q : bus.in_data;

  pipe_slot_reg #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_skid (
    .clk    (clk),
    .resetn (resetn),
    .load   (load_skid),
    .d      (bus.in_data),
    .q      (skid_q)
  );
`else
  logic ready_en;

  // Keeps in_ready low during reset and up from the first edge after release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ready_en <= 1'b0;
    else ready_en <= 1'b1;
  end

  assign bus.in_ready = ready_en & (~main_valid | bus.out_ready) & ~bus.hold;
  assign main_d       = bus.in_data;
`endif

  pipe_slot_reg #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_main (
    .clk    (clk),
    .resetn (resetn),
    .load   (load_main),
    .d      (main_d),
    .q      (main_q)
  );

  // Stage state register; async reset empties the stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_EMPTY;
    else state <= state_n;
  end

  // Next state and slot loads; flush empties the stage without touching payload.
  always_comb begin
    state_n   = state;
    load_main = 1'b0;
`ifdef PIPE_SKID_BUF_EN
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
`endif
    if (bus.flush) begin
      state_n = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_n   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire) begin
`ifdef PIPE_SKID_BUF_EN
            if (out_fire) begin
              load_main = 1'b1;
            end else begin
              state_n   = ST_FULL;
              load_skid = 1'b1;
            end
`else
            load_main = 1'b1;
`endif
          end else if (out_fire) begin
            state_n = ST_EMPTY;
          end
        end
        ST_FULL: begin
`ifdef PIPE_SKID_BUF_EN
          if (out_fire) begin
            state_n        = ST_ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
`else
          state_n = ST_EMPTY;
`endif
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the stimulus side pushes each accepted
// item into an expected FIFO (or empties it on flush); the monitor checks the
// outputs every cycle and pops on each emitted item. Works with or without
// PIPE_SKID_BUF_EN (capacity 2 or 1).
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DATA_W)) bus ();

  pipe_stage_reg #(.DATA_W(DATA_W), .RESET_VAL('0)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          emitted = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_q[$];
  int          msz;
  logic        m_ov;
  logic        m_ir;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then record what the stage should have taken.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic ordy,
                               input logic h, input logic f);
    int   sz;
    logic rdy_exp;
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.hold      = h;
    bus.flush     = f;
    sz = exp_q.size();
`ifdef PIPE_SKID_BUF_EN
    rdy_exp = (sz < 2) && !h;
`else
    rdy_exp = (sz == 0 || ordy) && !h;
`endif
    @(negedge clk);
    #2;
    if (f) exp_q.delete();
    else if (v && rdy_exp) exp_q.push_back(d);
  endtask

  // Monitor: compare outputs with the expected FIFO and retire emitted items.
  always @(negedge clk) begin
    if (mon_en) begin
      msz  = exp_q.size();
      m_ov = (msz > 0) && !bus.hold;
`ifdef PIPE_SKID_BUF_EN
      m_ir = (msz < 2) && !bus.hold;
`else
      m_ir = (msz == 0 || bus.out_ready) && !bus.hold;
`endif
      checkOutput("out_valid", {31'b0, bus.out_valid}, {31'b0, m_ov});
      checkOutput("in_ready", {31'b0, bus.in_ready}, {31'b0, m_ir});
      checkOutput("occupancy", {30'b0, bus.occupancy}, msz);
      if (m_ov && bus.out_valid) checkOutput("out_data", bus.out_data, exp_q[0]);
      if (m_ov && bus.out_ready) begin
        void'(exp_q.pop_front());
        emitted++;
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.hold      = 1'b0;
    bus.flush     = 1'b0;
    resetn        = 1'b0;

    #12;
    checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_occupancy", {30'b0, bus.occupancy}, 32'd0);
    checkOutput("rst_out_data", bus.out_data, 32'd0);
    checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(negedge clk);
    #3;
    resetn = 1'b1;
    mon_en = 1'b1;

    // Streaming 0x1..0x10 with the sink always ready.
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, i, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Backpressure then release.
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Hold with main = 0x33 and 0x44 waiting upstream.
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h44, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Flush beats hold and the incoming 0x55.
    applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Continuous input with out_ready toggling 1,0,1.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'h100 + i, (i % 3) != 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a stream.
    applyStimulus(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hA5A5_0002, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    bus.in_valid = 1'b0;
    resetn = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("midrst_occupancy", {30'b0, bus.occupancy}, 32'd0);
    checkOutput("midrst_out_data", bus.out_data, 32'd0);
    checkOutput("midrst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(negedge clk);
    #3;
    resetn = 1'b1;
    mon_en = 1'b1;
    applyStimulus(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    checkOutput("drained", exp_q.size(), 32'd0);
    checkOutput("items_seen", {31'b0, emitted > 20}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
